// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control: funct codes, ALUOp encodings,
// ALU operation codes and the multiply/divide FSM states.
package alu_ctrl_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_SLTU    = 4'b1000;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_UNKNOWN = 4'b1110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative engine: shift-add multiplier and restoring divider on
// operand magnitudes, with the iteration counter and final sign fix-up.
module muldiv_iter #(
    parameter int NBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic             signed_i,
    input  logic [NBITS-1:0] op_a_i,
    input  logic [NBITS-1:0] op_b_i,
    output logic             last_o,
    output logic             div_zero_o,
    output logic [NBITS-1:0] hi_o,
    output logic [NBITS-1:0] lo_o
);

    localparam int CW = $clog2(NBITS + 1);

    logic [CW-1:0]    count_q, count_d;
    logic [NBITS-1:0] acc_q, acc_d;
    logic [NBITS-1:0] low_q, low_d;
    logic [NBITS-1:0] opb_q, opb_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;

    logic             a_neg, b_neg;
    logic [NBITS-1:0] a_mag, b_mag;

    assign a_neg = signed_i & op_a_i[NBITS-1];
    assign b_neg = signed_i & op_b_i[NBITS-1];
    assign a_mag = a_neg ? -op_a_i : op_a_i;
    assign b_mag = b_neg ? -op_b_i : op_b_i;

    // acc holds the product high half / partial remainder; low holds the
    // multiplier shifting out / dividend shifting out as quotient shifts in.
    logic [NBITS:0]   mul_sum, div_shift;
    logic [NBITS-1:0] div_diff, acc_step, low_step;
    logic             div_fits;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, low_q[NBITS-1]};
        div_diff  = div_shift[NBITS-1:0] - opb_q;
        div_fits  = (div_shift >= {1'b0, opb_q});
        if (div_q) begin
            acc_step = div_fits ? div_diff : div_shift[NBITS-1:0];
            low_step = {low_q[NBITS-2:0], div_fits};
        end else begin
            acc_step = mul_sum[NBITS:1];
            low_step = {mul_sum[0], low_q[NBITS-1:1]};
        end
    end

    logic [2*NBITS-1:0] prod, prod_fixed;

    always_comb begin
        prod       = {acc_step, low_step};
        prod_fixed = neg_res_q ? -prod : prod;
        if (div_q) begin
            hi_o = neg_rem_q ? -acc_step : acc_step;
            lo_o = div_zero_q ? '1 : (neg_res_q ? -low_step : low_step);
        end else begin
            hi_o = prod_fixed[2*NBITS-1:NBITS];
            lo_o = prod_fixed[NBITS-1:0];
        end
    end

    always_comb begin
        count_d    = count_q;
        acc_d      = acc_q;
        low_d      = low_q;
        opb_d      = opb_q;
        div_d      = div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        if (load_i) begin
            count_d    = CW'(NBITS);
            acc_d      = '0;
            low_d      = a_mag;
            opb_d      = b_mag;
            div_d      = div_i;
            neg_res_d  = a_neg ^ b_neg;
            neg_rem_d  = div_i & a_neg;
            div_zero_d = div_i & (op_b_i == '0);
        end else if (step_i) begin
            count_d = count_q - CW'(1);
            acc_d   = acc_step;
            low_d   = low_step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            acc_q      <= '0;
            low_q      <= '0;
            opb_q      <= '0;
            div_q      <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            acc_q      <= acc_d;
            low_q      <= low_d;
            opb_q      <= opb_d;
            div_q      <= div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign last_o     = (count_q == CW'(1));
    assign div_zero_o = div_zero_q;

endmodule

// File: rtl/alu_muldiv_control.sv
// EX-stage ALU control: ALUOp/funct decode, HI/LO pair and iterative mul/div.
// Define ALU_MULDIV_EN to build HI/LO, the FSM and the muldiv_iter engine.
module alu_muldiv_control
    import alu_ctrl_pkg::*;
#(
    parameter int NBITS        = 32,
    parameter int ANBITS       = 6,
    parameter int NBITSCONTROL = 2,
    parameter int ALUOP        = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_Valid,
    input  logic [ANBITS-1:0]       i_Funct,
    input  logic [NBITSCONTROL-1:0] i_ALUOp,
    input  logic [NBITS-1:0]        i_OpA,
    input  logic [NBITS-1:0]        i_OpB,
    output logic [ALUOP-1:0]        o_ALUOp,
    output logic                    o_Stall,
    output logic                    o_HiLoSel,
    output logic [NBITS-1:0]        o_HiLoData,
    output logic                    o_Busy,
    output logic                    o_DivZero
);

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] HILO_ALUOP = ALU_ADD;
`else
    localparam logic [3:0] HILO_ALUOP = ALU_UNKNOWN;
`endif

    logic is_rtype;
    assign is_rtype = (i_ALUOp == ALUOP_RTYPE);

    always_comb begin
        o_ALUOp = ALU_ILLEGAL;
        case (i_ALUOp)
            ALUOP_ADD: o_ALUOp = ALU_ADD;
            ALUOP_SUB: o_ALUOp = ALU_SUB;
            ALUOP_RTYPE: begin
                case (i_Funct)
                    FUNCT_ADD, FUNCT_ADDU: o_ALUOp = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: o_ALUOp = ALU_SUB;
                    FUNCT_AND:  o_ALUOp = ALU_AND;
                    FUNCT_OR:   o_ALUOp = ALU_OR;
                    FUNCT_XOR:  o_ALUOp = ALU_XOR;
                    FUNCT_NOR:  o_ALUOp = ALU_NOR;
                    FUNCT_SLT:  o_ALUOp = ALU_SLT;
                    FUNCT_SLTU: o_ALUOp = ALU_SLTU;
                    FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                    FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU:
                                o_ALUOp = HILO_ALUOP;
                    default:    o_ALUOp = ALU_UNKNOWN;
                endcase
            end
            default: o_ALUOp = ALU_ILLEGAL;
        endcase
    end

`ifdef ALU_MULDIV_EN
    state_e           state_q, state_d;
    logic [NBITS-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [NBITS-1:0] res_hi, res_lo;
    logic             is_muldiv, is_div, is_signed, start, step, last, div_zero;

    assign is_muldiv = is_rtype && (i_Funct == FUNCT_MULT || i_Funct == FUNCT_MULTU ||
                                    i_Funct == FUNCT_DIV  || i_Funct == FUNCT_DIVU);
    assign is_div    = (i_Funct == FUNCT_DIV)  || (i_Funct == FUNCT_DIVU);
    assign is_signed = (i_Funct == FUNCT_MULT) || (i_Funct == FUNCT_DIV);
    // Gated by reset so the stall drops the instant reset is asserted.
    assign start     = i_reset && i_Valid && is_muldiv && (state_q == ST_IDLE);
    assign step      = (state_q == ST_MUL) || (state_q == ST_DIV);

    muldiv_iter #(
        .NBITS(NBITS)
    ) u_muldiv_iter (
        .clk_i      (i_clk),
        .rst_ni     (i_reset),
        .load_i     (start),
        .step_i     (step),
        .div_i      (is_div),
        .signed_i   (is_signed),
        .op_a_i     (i_OpA),
        .op_b_i     (i_OpB),
        .last_o     (last),
        .div_zero_o (div_zero),
        .hi_o       (res_hi),
        .lo_o       (res_lo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = is_div ? ST_DIV : ST_MUL;
            ST_MUL, ST_DIV: if (last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (step && last) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (state_q == ST_IDLE && i_Valid && is_rtype) begin
            if (i_Funct == FUNCT_MTHI) hi_d = i_OpA;
            if (i_Funct == FUNCT_MTLO) lo_d = i_OpA;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign o_Stall    = start || step;
    assign o_Busy     = step;
    assign o_DivZero  = (state_q == ST_DONE) && div_zero;
    assign o_HiLoSel  = is_rtype && (i_Funct == FUNCT_MFHI || i_Funct == FUNCT_MFLO);
    assign o_HiLoData = !o_HiLoSel ? '0 : ((i_Funct == FUNCT_MFHI) ? hi_q : lo_q);
`else
    logic unused_inputs;
    assign unused_inputs = ^{i_clk, i_reset, i_Valid, i_OpA, i_OpB};

    assign o_Stall    = 1'b0;
    assign o_Busy     = 1'b0;
    assign o_DivZero  = 1'b0;
    assign o_HiLoSel  = 1'b0;
    assign o_HiLoData = '0;
`endif

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Bench for alu_muldiv_control: spec-level model checked every cycle plus
// directed vectors with hand-computed results (follows ALU_MULDIV_EN).
module tb_alu_muldiv_control;

`ifdef ALU_MULDIV_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [1:0] RT = 2'b10;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        i_Valid = 1'b0;
    logic [5:0]  i_Funct = '0;
    logic [1:0]  i_ALUOp = '0;
    logic [31:0] i_OpA = '0, i_OpB = '0;
    logic [3:0]  o_ALUOp;
    logic        o_Stall, o_HiLoSel, o_Busy, o_DivZero;
    logic [31:0] o_HiLoData;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    alu_muldiv_control dut (
        .i_clk(clk), .i_reset(rst_n), .i_Valid(i_Valid), .i_Funct(i_Funct),
        .i_ALUOp(i_ALUOp), .i_OpA(i_OpA), .i_OpB(i_OpB), .o_ALUOp(o_ALUOp),
        .o_Stall(o_Stall), .o_HiLoSel(o_HiLoSel), .o_HiLoData(o_HiLoData),
        .o_Busy(o_Busy), .o_DivZero(o_DivZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b1111;
        case (f)
            6'h20, 6'h21: return 4'b0010;
            6'h22, 6'h23: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h26: return 4'b0011;
            6'h27: return 4'b1100;
            6'h2A: return 4'b0111;
            6'h2B: return 4'b1000;
            6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B:
                return EN ? 4'b0010 : 4'b1110;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic bit is_md(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    // Returns {HI, LO} using plain language arithmetic.
    function automatic logic [63:0] ref_res(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     qa, qb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        qa = $signed(a);
        qb = $signed(b);
        case (f)
            F_MULT:  return 64'(sa * sb);
            F_MULTU: return {32'h0, a} * {32'h0, b};
            F_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(qa % qb), 32'(qa / qb)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Model: an accepted start keeps the unit busy 32 cycles, then one DONE cycle.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;
    logic        m_done = 1'b0, m_dz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0; m_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (!m_done && EN && i_Valid && i_ALUOp == RT) begin
                if (is_md(i_Funct)) begin
                    m_pend <= ref_res(i_Funct, i_OpA, i_OpB);
                    m_left <= 32;
                    m_dz   <= (i_Funct == F_DIV || i_Funct == F_DIVU) && (i_OpB == 32'h0);
                end else if (i_Funct == F_MTHI) begin
                    m_hi <= i_OpA;
                end else if (i_Funct == F_MTLO) begin
                    m_lo <= i_OpA;
                end
            end
        end
    end

    logic        e_stall, e_sel;
    logic [31:0] e_data;
    assign e_stall = (m_left > 0) ||
                     (EN && rst_n && m_left == 0 && !m_done && i_Valid && i_ALUOp == RT && is_md(i_Funct));
    assign e_sel   = EN && (i_ALUOp == RT) && (i_Funct == F_MFHI || i_Funct == F_MFLO);
    assign e_data  = !e_sel ? 32'h0 : ((i_Funct == F_MFHI) ? m_hi : m_lo);

    always @(negedge clk) begin
        chk("alu_op", 32'(o_ALUOp), 32'(ref_alu(i_ALUOp, i_Funct)));
        chk("stall", 32'(o_Stall), 32'(e_stall));
        chk("busy", 32'(o_Busy), 32'(m_left > 0));
        chk("divzero", 32'(o_DivZero), 32'(m_done && m_dz));
        chk("hilo_sel", 32'(o_HiLoSel), 32'(e_sel));
        chk("hilo_data", o_HiLoData, e_data);
    end

    int          r_stall, r_start_cyc, r_done_cyc;
    logic [31:0] r_data;
    logic        r_sel, r_dz;
    logic [3:0]  r_alu;

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        i_Valid = v; i_ALUOp = op; i_Funct = f; i_OpA = a; i_OpB = b;
    endtask

    task automatic wait_done();
        r_stall = 0;
        @(negedge clk);
        r_start_cyc = cyc;
        while (o_Stall === 1'b1 && r_stall < 100) begin
            r_stall++;
            @(negedge clk);
        end
        chk("done_wait", 32'(r_stall < 100), 32'd1);
        r_done_cyc = cyc;
        r_data = o_HiLoData; r_sel = o_HiLoSel; r_dz = o_DivZero; r_alu = o_ALUOp;
        $display("txn aluop=%b funct=%h a=%h b=%h stall=%0d alu=%b sel=%b data=%h dz=%b",
                 i_ALUOp, i_Funct, i_OpA, i_OpB, r_stall, r_alu, r_sel, r_data, r_dz);
    endtask

    task automatic exec(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, op, f, a, b);
        wait_done();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        exec(RT, F_MFHI, 32'h0, 32'h0);
        chk({name, "_hi"}, r_data, EN ? hi : 32'h0);
        chk({name, "_hi_sel"}, 32'(r_sel), 32'(EN));
        chk({name, "_hi_stall"}, r_stall, 0);
        exec(RT, F_MFLO, 32'h0, 32'h0);
        chk({name, "_lo"}, r_data, EN ? lo : 32'h0);
    endtask

    int done1;

    initial begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        #1 drive(1'b1, RT, F_MFHI, 32'h0, 32'h0);
        #1 chk("reset_hilo_data", o_HiLoData, 32'h0);
        chk("reset_stall", 32'(o_Stall), 32'd0);
        drive(1'b1, RT, F_MULT, 32'h5, 32'h6);
        #1 chk("reset_start_stall", 32'(o_Stall), 32'd0);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Decode
        exec(RT, 6'h23, 32'h0, 32'h0);     chk("dec_subu", 32'(r_alu), 32'h6);
        exec(RT, 6'h27, 32'h0, 32'h0);     chk("dec_nor", 32'(r_alu), 32'hC);
        exec(RT, 6'h3F, 32'h0, 32'h0);     chk("dec_unknown", 32'(r_alu), 32'hE);
        exec(2'b11, 6'h20, 32'h0, 32'h0);  chk("dec_illegal", 32'(r_alu), 32'hF);
        exec(2'b00, 6'h22, 32'h0, 32'h0);  chk("dec_add", 32'(r_alu), 32'h2);
        exec(RT, 6'h2B, 32'h0, 32'h0);     chk("dec_sltu", 32'(r_alu), 32'h8);
        exec(RT, F_MULT, 32'h0, 32'h0);    chk("dec_mult", 32'(r_alu), EN ? 32'h2 : 32'hE);

        // Signed multiply
        exec(RT, F_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_stall", r_stall, EN ? 33 : 0);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Unsigned multiply
        exec(RT, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_stall", r_stall, EN ? 33 : 0);
        chk_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        // Divides
        exec(RT, F_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_dz", 32'(r_dz), 32'd0);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        exec(RT, F_DIVU, 32'd7, 32'd0);
        chk("divu0_dz", 32'(r_dz), 32'(EN));
        chk_hilo("divu0", 32'd7, 32'hFFFF_FFFF);
        exec(RT, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk_hilo("div_ovf", 32'h0, 32'h8000_0000);
        exec(RT, F_DIVU, 32'd100, 32'd7);
        chk_hilo("divu", 32'd2, 32'd14);

        // MTLO / MTHI
        exec(RT, F_MTLO, 32'h1234_5678, 32'h0);
        chk("mtlo_stall", r_stall, 0);
        exec(RT, F_MTHI, 32'hCAFE_0001, 32'h0);
        chk_hilo("mt", 32'hCAFE_0001, 32'h1234_5678);

        // Back-to-back
        exec(RT, F_MULT, 32'd5, 32'd7);
        done1 = r_done_cyc;
        exec(RT, F_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("b2b_start_gap", r_start_cyc - done1, 1);
        chk("b2b_stall", r_stall, EN ? 33 : 0);

        // Reset in iteration cycle 10 of a MULT
        drive(1'b1, RT, F_MULT, 32'h4000_0000, 32'd8);
        @(negedge clk);
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", 32'(o_Busy), 32'(EN));
        #2 rst_n = 1'b0;
        #1 chk("midrst_stall", 32'(o_Stall), 32'd0);
        chk("midrst_busy", 32'(o_Busy), 32'd0);
        drive(1'b1, RT, F_MFHI, 32'h0, 32'h0);
        #1 chk("midrst_hi", o_HiLoData, 32'h0);
        drive(1'b1, RT, F_MFLO, 32'h0, 32'h0);
        #1 chk("midrst_lo", o_HiLoData, 32'h0);
        drive(1'b1, RT, F_MULT, 32'h4000_0000, 32'd8);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_done();
        chk("restart_stall", r_stall, EN ? 33 : 0);
        @(posedge clk);
        #1;
        chk_hilo("restart", 32'd2, 32'd0);

        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_control.md
# alu_muldiv_control

Second-generation ALU control for the MIPS EX stage. It decodes `i_ALUOp`/`i_Funct` into the 4-bit ALU operation for the full R-type logic/arithmetic set. It also owns the HI/LO register pair and runs an iterative multiply/divide engine. While an operation is in progress it stalls the pipeline, and it drives the MFHI/MFLO result path into the EX result mux.

## Interface
- `NBITS`, 32, datapath width (operands, HI, LO)
- `ANBITS`, 6, funct field width
- `NBITSCONTROL`, 2, main-control ALUOp width
- `ALUOP`, 4, ALU operation code width
- `i_clk` in 1: single clock, rising edge
- `i_reset` in 1: **asynchronous, active-low** reset
- `i_Valid` in 1: EX holds a real instruction (not a bubble)
- `i_Funct` in `ANBITS`: instruction funct field
- `i_ALUOp` in `NBITSCONTROL`: 00 add, 01 sub, 10 R-type, 11 illegal
- `i_OpA` in `NBITS`: rs value (multiplicand/dividend, MTHI/MTLO source)
- `i_OpB` in `NBITS`: rt value (multiplier/divisor)
- `o_ALUOp` out `ALUOP`: ALU operation, combinational
- `o_Stall` out 1: freeze IF/ID/EX while high
- `o_HiLoSel` out 1: EX result mux selects `o_HiLoData`
- `o_HiLoData` out `NBITS`: HI (MFHI) or LO (MFLO)
- `o_Busy` out 1: engine in MUL/DIV state
- `o_DivZero` out 1: one-cycle pulse in DONE of a divide with `i_OpB == 0`

## Operation
- **ALUOp decode:**
  - ALUOp 00 → 0010.
  - ALUOp 01 → 0110.
  - ALUOp 11 → 1111.
- **R-type (ALUOp 10) funct decode:**
  - ADD 100000 and ADDU 100001 → 0010.
  - SUB 100010 and SUBU 100011 → 0110.
  - AND 100100 → 0000; OR 100101 → 0001; XOR 100110 → 0011; NOR 100111 → 1100.
  - SLT 101010 → 0111; SLTU 101011 → 1000.
  - HI/LO functs (MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011) → 0010. The ALU result is ignored for these.
  - Any other funct → 1110.
- **MFHI/MFLO:** `o_HiLoSel`=1 and `o_HiLoData`=HI/LO, combinational. No stall.
- **MTHI/MTLO:** HI/LO ← `i_OpA` at the clock edge when `i_Valid` is high and the FSM is in IDLE.
- **FSM states:**
  - IDLE: when the start condition holds, latch operands, count←`NBITS`, go to MUL or DIV.
  - MUL/DIV: perform one radix-2 iteration per cycle and decrement count. At count==1, write HI/LO and go to DONE.
  - DONE: no start accepted. Go to IDLE.
- **Start condition:** `i_Valid` & ALUOp==10 & funct ∈ {MULT, MULTU, DIV, DIVU}.
- **Signed operations:** operate on magnitudes; fix signs at completion.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ; the remainder takes the dividend's sign.
- **Multiply result:** full 2·`NBITS` product; HI = upper half, LO = lower half.
- **Divide result:** LO = quotient, HI = remainder.
- **Divide by zero:** LO = all ones, HI = dividend, `o_DivZero` pulses.
- **Signed overflow:** -2^(N-1) / -1 gives LO = 0x80000000, HI = 0.
- **`i_Valid` deassertion:** has no effect on a running operation.

## Timing
- `o_ALUOp`, `o_HiLoSel`, `o_HiLoData`: zero latency.
- `o_Stall` = (IDLE & start condition) | MUL | DIV.
  - High for `NBITS`+1 cycles: the start cycle plus `NBITS` iteration cycles.
  - Low in DONE, so the instruction leaves EX at the end of DONE.
- HI/LO hold the new value from the first DONE cycle.
- A back-to-back MULT/DIV starts in the cycle after DONE.
- MFHI issued immediately after a MULT sees the new result.
- **Reset (asynchronous, active-low), including mid-operation:**
  - FSM → IDLE; HI=LO=0; counter=0.
  - `o_Stall`=`o_Busy`=`o_DivZero`=0 immediately.
  - No partial result is written.
  - `o_ALUOp`/`o_HiLoSel`/`o_HiLoData` follow their inputs; `o_HiLoData`=0.

## Configuration
- Macro: `ALU_MULDIV_EN`.
- **Defined:** behaviour as specified above.
- **Undefined:**
  - No HI/LO registers, engine or FSM.
  - HI/LO functs decode as unknown (1110).
  - `o_Stall`, `o_Busy`, `o_HiLoSel`, `o_DivZero` tied to 0; `o_HiLoData` tied to 0.

## Structure
- Package `alu_ctrl_pkg` holds:
  - all funct codes;
  - the ALUOp encodings (00/01/10/11);
  - the 4-bit ALU operation codes, including unknown-funct 1110 and illegal 1111;
  - the FSM state encoding (IDLE/MUL/DIV/DONE).
- Sub-module `muldiv_iter`, instantiated only under `ALU_MULDIV_EN`, holds:
  - shift-add multiplier and restoring divider datapath;
  - iteration counter;
  - sign fix-up logic.
- The top level keeps the decode, the FSM, HI/LO, and the stall and result-mux logic.

## Test plan
- **Decode:** ALUOp=10 with SUBU 100011 → 0110; NOR → 1100; funct 111111 → 1110; ALUOp=11 → 1111; ALUOp=00 → 0010.
- **Signed multiply:** MULT A=0xFFFFFFFE, B=3 → `o_Stall` high exactly 33 cycles, DONE with HI=0xFFFFFFFF, LO=0xFFFFFFFA. Then MFHI → `o_HiLoSel`=1, `o_HiLoData`=0xFFFFFFFF.
- **Unsigned multiply:** MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- **Divide:**
  - DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/0 → LO=0xFFFFFFFF, HI=7, `o_DivZero` pulses one cycle in DONE.
- **Reset mid-operation:** assert `i_reset` low in iteration cycle 10 of a MULT → stall drops immediately, HI=LO=0. After release, the MULT restarts and completes correctly.
- **MTLO and back-to-back:** MTLO 0x12345678, then MFLO → `o_HiLoData`=0x12345678 with no stall. Back-to-back MULT/MULT → the second starts in the cycle after the first's DONE.
